// File: rtl/chdr_pkg.sv
// ============================================================================
// Module      : chdr_pkg
// Description : Shared state encodings and CHDR header constants for the
//               sc16 -> sc8 narrowing converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chdr_pkg;

  // Converter state; the encodings are visible on the debug port.
  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_TIME   = 2'd1,
    ST_FIRST  = 2'd2,
    ST_SECOND = 2'd3
  } chdr_state_t;

  // Header word bit that flags a timestamp beat following the header.
  localparam int CHDR_HAS_TIME_BIT = 61;

  // Header size in bytes without and with the timestamp beat.
  localparam logic [15:0] CHDR_HDR_BYTES_NO_TIME = 16'd8;
  localparam logic [15:0] CHDR_HDR_BYTES_TIME    = 16'd16;

endpackage

`default_nettype wire

// File: rtl/chdr_s16_to_s8_lane.sv
// ============================================================================
// Module      : chdr_s16_to_s8_lane
// Description : Combinational narrower, one signed 16-bit component to 8 bits.
//               Default build truncates (keeps bits [15:8]).
//               With CHDR_16S_TO_8S_ROUND_EN defined the component is rounded
//               half-up (+0x0080) and clamped to 0x7F on positive overflow
//               before the high byte is taken.
// Ports       : in_sample  [15:0] signed 16-bit component
//               out_sample [7:0]  narrowed 8-bit component
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chdr_s16_to_s8_lane (
  input  logic [15:0] in_sample,
  output logic [7:0]  out_sample
);

`ifdef CHDR_16S_TO_8S_ROUND_EN
  logic [15:0] w_sum;

  assign w_sum = in_sample + 16'h0080;
  // Only a non-negative input can wrap to negative when 0x80 is added.
  assign out_sample = (!in_sample[15] && w_sum[15]) ? 8'h7F : w_sum[15:8];
`else
  logic w_unused_low;

  assign w_unused_low = ^in_sample[7:0];
  assign out_sample   = in_sample[15:8];
`endif

endmodule

`default_nettype wire

// File: rtl/chdr_16s_to_8s.sv
// ============================================================================
// Module      : chdr_16s_to_8s
// Description : CHDR sc16 -> sc8 narrowing converter. Header length field is
//               rewritten for the halved payload, the timestamp beat passes
//               unchanged, and each pair of input payload beats is packed
//               into one output beat. The SID destination can be replaced
//               through a settings-bus register at address BASE.
//               Optional build macro: CHDR_16S_TO_8S_ROUND_EN (round-half-up
//               with positive saturation instead of truncation).
// Ports       : clk, rst             clock, asynchronous active-high reset
//               i_tdata/tlast/tvalid/tready   CHDR input stream
//               o_tdata/tlast/tvalid/tready   CHDR output stream
//               set_stb/set_addr/set_data     settings bus
//               debug [31:0]         {state[1:0], hold_valid, 29'b0}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chdr_16s_to_8s #(
  parameter int BASE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic [31:0] debug
);

  import chdr_pkg::*;

  localparam logic [7:0] c_base_addr = BASE[7:0];

  chdr_state_t r_state;
  chdr_state_t w_next;
  logic [31:0] r_hold;
  logic        r_set_sid;
  logic [15:0] r_new_sid_dst;
  logic [31:0] w_narrow;
  logic [15:0] w_hdr_bytes;
  logic [15:0] w_size;
  logic        w_hold_load;
  logic        w_unused_set;

  assign w_unused_set = ^set_data[31:17];

  // Settings register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_sid     <= 1'b0;
      r_new_sid_dst <= 16'h0000;
    end else if (set_stb && (set_addr == c_base_addr)) begin
      r_set_sid     <= set_data[16];
      r_new_sid_dst <= set_data[15:0];
    end
  end

  // Four lane narrowers, MSB lane lands in the MSB output byte.
  genvar g_i;
  generate
    for (g_i = 0; g_i < 4; g_i++) begin : g_lane
      chdr_s16_to_s8_lane u_lane (
        .in_sample  (i_tdata[16*g_i +: 16]),
        .out_sample (w_narrow[8*g_i +: 8])
      );
    end
  endgenerate

  // Payload byte count is halved; header bytes are kept as-is.
  assign w_hdr_bytes = i_tdata[CHDR_HAS_TIME_BIT] ? CHDR_HDR_BYTES_TIME
                                                  : CHDR_HDR_BYTES_NO_TIME;
  assign w_size      = ((i_tdata[47:32] - w_hdr_bytes) >> 1) + w_hdr_bytes;

  // FIRST always accepts a non-last beat, so it loads on i_tvalid alone.
  assign w_hold_load = (r_state == ST_FIRST) && !i_tlast && i_tvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HEADER;
      r_hold  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_hold_load) begin
        r_hold <= w_narrow;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    o_tdata  = i_tdata;
    o_tlast  = i_tlast;
    o_tvalid = i_tvalid;
    i_tready = o_tready;
    case (r_state)
      ST_HEADER: begin
        o_tdata = {i_tdata[63:48], w_size,
                   r_set_sid ? {i_tdata[15:0], r_new_sid_dst} : i_tdata[31:0]};
        if (i_tvalid && o_tready && !i_tlast) begin
          w_next = i_tdata[CHDR_HAS_TIME_BIT] ? ST_TIME : ST_FIRST;
        end
      end
      ST_TIME: begin
        if (i_tvalid && o_tready) begin
          w_next = i_tlast ? ST_HEADER : ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (i_tlast) begin
          // Odd payload: emit the lone beat zero-padded in the low half.
          o_tdata = {w_narrow, 32'h0};
          o_tlast = 1'b1;
          if (i_tvalid && o_tready) begin
            w_next = ST_HEADER;
          end
        end else begin
          i_tready = 1'b1;
          o_tvalid = 1'b0;
          if (i_tvalid) begin
            w_next = ST_SECOND;
          end
        end
      end
      ST_SECOND: begin
        o_tdata = {r_hold, w_narrow};
        if (i_tvalid && o_tready) begin
          w_next = i_tlast ? ST_HEADER : ST_FIRST;
        end
      end
      default: begin
        w_next = ST_HEADER;
      end
    endcase
  end

  assign debug = {r_state, (r_state == ST_SECOND), 29'b0};

endmodule

`default_nettype wire

// File: tb/tb_chdr_16s_to_8s.sv
// ============================================================================
// Module      : tb_chdr_16s_to_8s
// Description : Self-checking bench for chdr_16s_to_8s. Directed packets from
//               the test plan, then randomized packets under random valid and
//               ready throttling, checked against a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chdr_16s_to_8s;

  localparam int c_base = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] debug;

  int checks   = 0;
  int failures = 0;

  // {tlast, tdata}
  logic [64:0] in_q[$];
  logic [64:0] exp_q[$];

  // Model of the SID override register
  bit          m_sid_en  = 1'b0;
  logic [15:0] m_sid_dst = 16'h0;

  always #5 clk = ~clk;

  chdr_16s_to_8s #(.BASE(c_base)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .debug    (debug)
  );

`ifdef CHDR_16S_TO_8S_ROUND_EN
  localparam logic [63:0] c_exp_two_beat = 64'h1256_9BDF_1122_3344;
  localparam logic [63:0] c_exp_odd      = 64'h1256_9BDF_0000_0000;
  localparam logic [63:0] c_exp_lanes    = 64'h137F_FF13_0000_0000;
`else
  localparam logic [63:0] c_exp_two_beat = 64'h1256_9ADE_1122_3344;
  localparam logic [63:0] c_exp_odd      = 64'h1256_9ADE_0000_0000;
  localparam logic [63:0] c_exp_lanes    = 64'h127F_FF12_0000_0000;
`endif

  task automatic chk(input string tag, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    assert (act === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference narrowing from signed arithmetic on the component value.
  function automatic logic [7:0] ref_lane(input logic [15:0] s);
    int v;
    v = $signed(s);
`ifdef CHDR_16S_TO_8S_ROUND_EN
    v = v + 128;
    if (v > 32767) v = 32767;
`endif
    return 8'(v >>> 8);
  endfunction

  function automatic logic [31:0] ref_narrow(input logic [63:0] w);
    return {ref_lane(w[63:48]), ref_lane(w[47:32]), ref_lane(w[31:16]), ref_lane(w[15:0])};
  endfunction

  // Builds one random packet and its expected output stream.
  task automatic add_random_pkt();
    bit          has_time;
    int          n;
    int          hb;
    int          len;
    logic [15:0] top;
    logic [31:0] low;
    logic [63:0] tbeat;
    logic [63:0] pl[$];
    has_time = 1'($urandom_range(0, 1));
    n        = $urandom_range(0, 5);
    hb       = has_time ? 16 : 8;
    len      = hb + 8 * n;
    top      = 16'($urandom);
    top[13]  = has_time;
    low      = $urandom;
    in_q.push_back({(n == 0 && !has_time), top, 16'(len), low});
    exp_q.push_back({(n == 0 && !has_time), top, 16'(hb + (len - hb) / 2),
                     m_sid_en ? {low[15:0], m_sid_dst} : low});
    if (has_time) begin
      tbeat = {$urandom, $urandom};
      in_q.push_back({(n == 0), tbeat});
      exp_q.push_back({(n == 0), tbeat});
    end
    for (int i = 0; i < n; i++) begin
      pl.push_back({$urandom, $urandom});
      in_q.push_back({(i == n - 1), pl[i]});
    end
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) exp_q.push_back({(i + 1 == n - 1), ref_narrow(pl[i]), ref_narrow(pl[i+1])});
      else           exp_q.push_back({1'b1, ref_narrow(pl[i]), 32'h0});
    end
  endtask

  task automatic set_reg(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  // Streams in_q through the DUT and checks every output beat against exp_q.
  task automatic run_traffic(input int vpct, input int rpct);
    int          cyc     = 0;
    bit          stalled = 1'b0;
    logic [63:0] stall_data = '0;
    bit          in_fire;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
      if (!i_tvalid && in_q.size() > 0 && $urandom_range(0, 99) < vpct) begin
        i_tvalid = 1'b1;
        {i_tlast, i_tdata} = in_q[0];
      end
      o_tready = ($urandom_range(0, 99) < rpct);
      @(negedge clk);
      if (stalled) chk("stall_stable", {o_tvalid, o_tdata}, {1'b1, stall_data});
      if (o_tvalid && o_tready) begin
        chk("out_expected", {64'h0, exp_q.size() != 0}, 65'd1);
        if (exp_q.size() != 0) chk("out_beat", {o_tlast, o_tdata}, exp_q.pop_front());
      end
      stalled    = o_tvalid && !o_tready;
      stall_data = o_tdata;
      in_fire    = i_tvalid && i_tready;
      @(posedge clk); #1;
      if (in_fire) begin
        void'(in_q.pop_front());
        i_tvalid = 1'b0;
      end
      cyc++;
    end
    chk("traffic_done", {64'h0, (in_q.size() == 0 && exp_q.size() == 0)}, 65'd1);
    in_q.delete();
    exp_q.delete();
    i_tvalid = 1'b0;
    o_tready = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b0;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_debug", {33'h0, debug}, {33'h0, 32'h0});
    chk("reset_ovalid", {64'h0, o_tvalid}, 65'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-beat packet, no timestamp
    in_q.push_back({1'b0, 64'h0000_0018_0000_ABCD});
    in_q.push_back({1'b0, 64'h1234_5678_9ABC_DEF0});
    in_q.push_back({1'b1, 64'h1111_2222_3333_4444});
    exp_q.push_back({1'b0, 64'h0000_0010_0000_ABCD});
    exp_q.push_back({1'b1, c_exp_two_beat});
    run_traffic(100, 100);

    // Timestamped packet, 16 payload bytes
    in_q.push_back({1'b0, 64'h2000_0020_0000_1234});
    in_q.push_back({1'b0, 64'hDEAD_BEEF_0123_4567});
    in_q.push_back({1'b0, 64'h0102_0304_0506_0708});
    in_q.push_back({1'b1, 64'h8000_7FFF_C0DE_0A0B});
    exp_q.push_back({1'b0, 64'h2000_0018_0000_1234});
    exp_q.push_back({1'b0, 64'hDEAD_BEEF_0123_4567});
    exp_q.push_back({1'b1, ref_narrow(64'h0102_0304_0506_0708), ref_narrow(64'h8000_7FFF_C0DE_0A0B)});
    run_traffic(100, 100);

    // Odd payload, single beat
    in_q.push_back({1'b0, 64'h0000_0010_0000_0001});
    in_q.push_back({1'b1, 64'h1234_5678_9ABC_DEF0});
    exp_q.push_back({1'b0, 64'h0000_000C_0000_0001});
    exp_q.push_back({1'b1, c_exp_odd});
    run_traffic(100, 100);

    // Lane rounding / saturation corner values
    in_q.push_back({1'b0, 64'h0000_0010_0000_0002});
    in_q.push_back({1'b1, 64'h1280_7FC0_FF7F_1280});
    exp_q.push_back({1'b0, 64'h0000_000C_0000_0002});
    exp_q.push_back({1'b1, c_exp_lanes});
    run_traffic(100, 100);

    // Timestamp-only packet: tlast on the time beat
    in_q.push_back({1'b0, 64'h2000_0010_0000_0003});
    in_q.push_back({1'b1, 64'h0000_0000_CAFE_F00D});
    exp_q.push_back({1'b0, 64'h2000_0010_0000_0003});
    exp_q.push_back({1'b1, 64'h0000_0000_CAFE_F00D});
    run_traffic(100, 100);

    // SID override on, a write to another address, then override off
    set_reg(8'(c_base), 32'h0001_BEEF);
    set_reg(8'(c_base + 1), 32'h0001_1234);
    in_q.push_back({1'b1, 64'h0000_0008_AAAA_5555});
    exp_q.push_back({1'b1, 64'h0000_0008_5555_BEEF});
    run_traffic(100, 100);
    set_reg(8'(c_base), 32'h0000_0000);
    in_q.push_back({1'b1, 64'h0000_0008_AAAA_5555});
    exp_q.push_back({1'b1, 64'h0000_0008_AAAA_5555});
    run_traffic(100, 100);

    // Reset while holding the first half of a pair
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    i_tlast  = 1'b0;
    i_tdata  = 64'h0000_0018_0000_0004;
    @(posedge clk); #1;
    i_tdata  = 64'h7777_6666_5555_4444;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    chk("second_debug", {61'h0, debug[31:29]}, {61'h0, 3'b111});
    rst = 1'b1;
    #1;
    chk("async_reset_debug", {61'h0, debug[31:29]}, {61'h0, 3'b000});
    @(posedge clk); #1;
    rst      = 1'b0;
    o_tready = 1'b0;
    @(posedge clk); #1;
    in_q.push_back({1'b0, 64'h0000_0018_0000_0005});
    in_q.push_back({1'b0, 64'h1234_5678_9ABC_DEF0});
    in_q.push_back({1'b1, 64'h1111_2222_3333_4444});
    exp_q.push_back({1'b0, 64'h0000_0010_0000_0005});
    exp_q.push_back({1'b1, c_exp_two_beat});
    run_traffic(100, 100);

    // Randomized packets under throttling, override off then on
    for (int p = 0; p < 50; p++) add_random_pkt();
    run_traffic(60, 50);
    m_sid_en  = 1'b1;
    m_sid_dst = 16'($urandom);
    set_reg(8'(c_base), {15'h0, 1'b1, m_sid_dst});
    for (int p = 0; p < 50; p++) add_random_pkt();
    run_traffic(70, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chdr_16s_to_8s.md
Name: chdr_16s_to_8s

Overview:
- Narrowing converter for CHDR sample streams: sc16 payload in, sc8 payload out.
- Takes the high byte of each 16-bit component, packs two input payload beats into one output beat, and rewrites the header length field (payload bytes halved).
- Sits in the TX/host-bound path, mirroring the sc8-to-sc16 widener; SID destination is optionally overridden via the settings bus.

Parameters:
- BASE, 0, settings-bus address of the SID override register.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_tdata  in  64  CHDR input beat.
- i_tlast  in  1  last input beat of packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  64  CHDR output beat.
- o_tlast  out  1  last output beat of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- set_stb  in  1  settings strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- debug  out  32  {state[1:0], hold_valid, 29'b0}.

Behaviour:
- Settings register:
  - On set_stb with set_addr==BASE, latch {set_sid, new_sid_dst[15:0]} = set_data[16:0].
  - Async reset to 0.
- Beat transfer: occurs when valid & ready on the respective side.
- States: HEADER, TIME, FIRST, SECOND (2-bit); async reset to HEADER. Hold register (32b) resets to 0.
- HEADER:
  - Combinational pass-through: o_tvalid=i_tvalid, i_tready=o_tready, o_tlast=i_tlast.
  - hdr = i_tdata[61] ? 16 : 8.
  - Output size = ((i_tdata[47:32]-hdr)>>1)+hdr, computed in 16-bit; a floor on odd payload length is accepted.
  - o_tdata = {i_tdata[63:48], size, set_sid ? {i_tdata[15:0], new_sid_dst} : i_tdata[31:0]}.
  - On transfer without tlast: go to TIME if bit 61 set, else FIRST. Transfer with tlast (header-only packet) stays in HEADER.
- TIME:
  - Pass-through unchanged.
  - On transfer: HEADER if tlast, else FIRST.
- FIRST (non-last beat):
  - i_tready=1, o_tvalid=0.
  - On transfer: hold <= narrow(i_tdata) (4 bytes, high byte of each 16-bit lane, MSB lane first); go to SECOND.
- FIRST (i_tlast=1):
  - Emit a padded beat combinationally: o_tdata={narrow(i_tdata), 32'h0}, o_tvalid=i_tvalid, i_tready=o_tready, o_tlast=1.
  - On transfer: go to HEADER.
- SECOND:
  - o_tdata={hold, narrow(i_tdata)}, o_tvalid=i_tvalid, i_tready=o_tready, o_tlast=i_tlast.
  - On transfer: HEADER if tlast, else FIRST.
- Latency:
  - Header, time and padded/combined beats are zero-cycle combinational.
  - A FIRST non-last beat produces no output and one hold-register cycle.
- Backpressure:
  - Held data is never lost; hold is only written on a FIRST non-last transfer.
  - o_tdata is stable while o_tvalid & !o_tready.
- Boundaries:
  - Zero-payload packet is header only.
  - tlast on TIME returns to HEADER.
  - Reset mid-packet returns to HEADER immediately and discards hold.
  - Settings write mid-packet takes effect on the next header.

Optional Feature:
- Macro: CHDR_16S_TO_8S_ROUND_EN.
- Defined: each lane is round-half-up; 16-bit two's-complement +0x0080, then saturate to 0x7F on positive overflow before taking the high byte.
- Undefined: pure truncation (bits [15:8]).
- Header, handshake and timing are identical in both builds.

Decomposition:
- Package chdr_pkg: state encodings (HEADER=0, TIME=1, FIRST=2, SECOND=3), CHDR_HAS_TIME_BIT=61, header byte constants 8/16.
- Sub-module chdr_s16_to_s8_lane: one 16-to-8 combinational narrower with the rounding option. Instantiate 4x; narrow() is 4 lanes.

Test Plan:
- Header 0x0000_0018_0000_ABCD (no time, size 24) plus two payload beats:
  - Input beats 0x1234_5678_9ABC_DEF0 and 0x1111_2222_3333_4444.
  - Output header size field 0x0010; one output beat 0x1256_9ADE_1122_3344 with tlast.
- Time packet, size 32:
  - Output header size 0x0018; time beat passed unchanged; one payload output beat.
- Odd payload, size 16, one beat 0x1234_5678_9ABC_DEF0 with tlast:
  - Output header size 0x000C; beat 0x1256_9ADE_0000_0000 with tlast.
- SID override:
  - Write BASE with 0x0001_BEEF; header low word 0xAAAA_5555 becomes 0x5555_BEEF.
  - Write 0: header passes unchanged.
- Random o_tready / i_tvalid throttling over 100 packets:
  - Output matches the golden model; no beat dropped or duplicated.
  - o_tdata stable under stall.
- Reset asserted while in SECOND: state returns to HEADER same cycle; next packet converts correctly.
- With ROUND_EN:
  - Lanes 0x1280 → 0x13, 0x7FC0 → 0x7F, 0xFF7F → 0xFF.
  - Without ROUND_EN: 0x1280 → 0x12.
